convolve_image_clked: RTL and testbench



---
 rtl/conv_pkg.sv | 31 +++
 rtl/conv_mac_sat.sv | 34 +++
 rtl/convolve_image_clked.sv | 141 ++++++++++++++
 tb/tb_convolve_image_clked.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and the saturating fixed-point shift
// used by the sequential convolution engine.
package conv_pkg;

  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 11;
  localparam int MAX_IMG = 32;
  localparam int MAX_K   = 5;
  localparam int ACC_W   = 40;
  localparam int PROD_W  = 2 * DATA_W;
  localparam int IMG_AW  = 10;
  localparam int FLT_AW  = 5;

  typedef enum logic [1:0] {IDLE, MAC, FIN} conv_state_t;

  // Arithmetic right shift back to Q4.11, clamped to the 16-bit signed range.
  function automatic logic signed [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] sh;
    logic signed [DATA_W-1:0] res;
    sh = v >>> FRAC_W;
    if (sh > ACC_W'(32767)) begin
      res = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (sh < ACC_W'(-32768)) begin
      res = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      res = sh[DATA_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_mac_sat.sv
// Multiply-accumulate slice: combinational product and saturated result of
// (acc + product), with the accumulator register reloaded to zero per pixel.
module conv_mac_sat
  import conv_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     accumulate,
  input  logic                     last,
  input  logic signed [DATA_W-1:0] pixel,
  input  logic signed [DATA_W-1:0] tap,
  output logic signed [DATA_W-1:0] result
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  acc_reg;

  assign prod   = PROD_W'(pixel) * PROD_W'(tap);
  assign sum    = acc_reg + ACC_W'(prod);
  assign result = sat_shift(sum);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg <= '0;
    end else if (clear) begin
      acc_reg <= '0;
    end else if (accumulate) begin
      acc_reg <= last ? '0 : sum;
    end
  end

endmodule

// File: rtl/convolve_image_clked.sv
// Sequential valid-mode 2-D cross-correlation: one MAC per clock, one
// saturated Q4.11 pixel per K*K cycles, emitted row-major with a done strobe.
module convolve_image_clked
  import conv_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [15:0]              imgSize,
  input  logic signed [DATA_W-1:0] image [MAX_IMG*MAX_IMG],
  input  logic [15:0]              filterSize,
  input  logic signed [DATA_W-1:0] filter [MAX_K*MAX_K],
  output logic signed [DATA_W-1:0] convolved,
  output logic                     done
);

  conv_state_t state_reg, state_next;

  logic [5:0] n_reg, m_last_reg, r_reg, c_reg;
  logic [2:0] k_last_reg, i_reg, j_reg;
  logic signed [DATA_W-1:0] convolved_reg;
  logic done_reg;

  logic sizes_ok, start, step, clear, last_tap, last_pix;
  logic [5:0] row, col;
  logic [IMG_AW-1:0] img_addr;
  logic [FLT_AW-1:0] flt_addr;
  logic signed [DATA_W-1:0] mac_result;

  assign sizes_ok = (filterSize != 16'd0) && (filterSize <= 16'd5) &&
                    (imgSize <= 16'd32) && (filterSize <= imgSize);

  assign last_tap = (i_reg == k_last_reg) && (j_reg == k_last_reg);
  assign last_pix = last_tap && (r_reg == m_last_reg) && (c_reg == m_last_reg);

  assign row      = r_reg + {3'b000, i_reg};
  assign col      = c_reg + {3'b000, j_reg};
  assign img_addr = IMG_AW'(row) * IMG_AW'(n_reg) + IMG_AW'(col);
  assign flt_addr = FLT_AW'(i_reg) * (FLT_AW'(k_last_reg) + FLT_AW'(1)) + FLT_AW'(j_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    step       = 1'b0;
    clear      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable) begin
          start      = 1'b1;
          clear      = 1'b1;
          state_next = sizes_ok ? MAC : FIN;
        end
      end
      MAC: begin
        // Dropping enable abandons the pixel in progress without a strobe.
        if (!enable) begin
          clear      = 1'b1;
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (last_pix) begin
            state_next = FIN;
          end
        end
      end
      FIN: begin
        if (!enable) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_reg         <= '0;
      k_last_reg    <= '0;
      m_last_reg    <= '0;
      i_reg         <= '0;
      j_reg         <= '0;
      r_reg         <= '0;
      c_reg         <= '0;
      convolved_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= step && last_tap;
      if (start) begin
        n_reg      <= imgSize[5:0];
        k_last_reg <= filterSize[2:0] - 3'd1;
        m_last_reg <= imgSize[5:0] - {3'b000, filterSize[2:0]};
        i_reg      <= '0;
        j_reg      <= '0;
        r_reg      <= '0;
        c_reg      <= '0;
      end else if (step) begin
        // Kernel column innermost, then kernel row, output column, output row.
        if (j_reg == k_last_reg) begin
          j_reg <= '0;
          if (i_reg == k_last_reg) begin
            i_reg         <= '0;
            convolved_reg <= mac_result;
            if (c_reg == m_last_reg) begin
              c_reg <= '0;
              r_reg <= r_reg + 6'd1;
            end else begin
              c_reg <= c_reg + 6'd1;
            end
          end else begin
            i_reg <= i_reg + 3'd1;
          end
        end else begin
          j_reg <= j_reg + 3'd1;
        end
      end
    end
  end

  conv_mac_sat u_mac (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .accumulate (step),
    .last       (last_tap),
    .pixel      (image[img_addr]),
    .tap        (filter[flt_addr]),
    .result     (mac_result)
  );

  assign convolved = convolved_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_convolve_image_clked.sv
// Directed and randomized checks of the convolution engine against a
// plain-arithmetic reference of the valid-mode cross-correlation.
module tb_convolve_image_clked;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic [15:0] imgSize, filterSize;
  logic signed [15:0] image [1024];
  logic signed [15:0] filter [25];
  logic signed [15:0] convolved;
  logic done;

  int checks = 0;
  int errors = 0;
  logic signed [15:0] got_q [$];

  always #5 clk = ~clk;

  convolve_image_clked dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .imgSize    (imgSize),
    .image      (image),
    .filterSize (filterSize),
    .filter     (filter),
    .convolved  (convolved),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // out(r,c) = sum image[(r+i)N+(c+j)] * filter[iK+j], then >>>11 and clamp
  function automatic logic signed [15:0] ref_pix(input int n, input int k, input int r, input int c);
    longint acc, sh;
    acc = 0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        acc += longint'(image[(r + i) * n + c + j]) * longint'(filter[i * k + j]);
    sh = acc >>> 11;
    if (sh > 32767) return 16'sh7fff;
    if (sh < -32768) return 16'sh8000;
    return 16'(sh);
  endfunction

  // Start a convolution and check every cycle until a few cycles into FIN.
  task automatic run_conv(input int n, input int k);
    int m, k2, total, p;
    logic signed [15:0] want, last_out;
    m = n - k + 1;
    k2 = k * k;
    total = m * m * k2;
    p = 0;
    last_out = '0;
    got_q.delete();
    @(negedge clk);
    imgSize = 16'(n);
    filterSize = 16'(k);
    enable = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= total + 2; t++) begin
      @(posedge clk);
      #1;
      if (t <= total && (t % k2) == 0) begin
        want = ref_pix(n, k, p / m, p % m);
        chk("done_strobe", 16'(done), 16'd1);
        chk("pixel", convolved, want);
        got_q.push_back(convolved);
        last_out = want;
        p++;
      end else begin
        chk("done_quiet", 16'(done), 16'd0);
        if (p > 0) chk("hold", convolved, last_out);
      end
    end
    chk("state_fin", 16'(dut.state_reg), 16'(FIN));
    $display("run N=%0d K=%0d strobes=%0d", n, k, got_q.size());
  endtask

  task automatic drop_enable();
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("state_idle", 16'(dut.state_reg), 16'(IDLE));
    chk("done_idle", 16'(done), 16'd0);
  endtask

  task automatic load_basic();
    for (int x = 0; x < 1024; x++) image[x] = 16'sh0400;
    image[3] = 16'shA000;
    for (int x = 0; x < 25; x++) filter[x] = 16'sh0800;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    imgSize = '0;
    filterSize = '0;
    for (int x = 0; x < 1024; x++) image[x] = '0;
    for (int x = 0; x < 25; x++) filter[x] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_convolved", convolved, 16'h0000);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_state", 16'(dut.state_reg), 16'(IDLE));
    @(negedge clk);
    reset = 1'b1;

    // Basic 6x6 with 3x3 unity kernel
    load_basic();
    run_conv(6, 3);
    chk("basic_count", 16'(got_q.size()), 16'd16);
    chk("basic_p0", got_q[0], 16'h2400);
    chk("basic_p1", got_q[1], 16'hC000);
    chk("basic_p3", got_q[3], 16'hC000);
    chk("basic_p15", got_q[15], 16'h2400);
    drop_enable();

    // Saturation both ways
    for (int x = 0; x < 25; x++) begin
      image[x] = 16'sh7fff;
      filter[x] = 16'sh7fff;
    end
    run_conv(5, 5);
    chk("sat_pos", got_q[0], 16'h7fff);
    drop_enable();
    for (int x = 0; x < 25; x++) filter[x] = 16'sh8000;
    run_conv(5, 5);
    chk("sat_neg", got_q[0], 16'h8000);
    drop_enable();

    // K=1 identity
    filter[0] = 16'sh0800;
    for (int x = 0; x < 16; x++) image[x] = 16'(x * 16'h0100);
    run_conv(4, 1);
    chk("k1_count", 16'(got_q.size()), 16'd16);
    chk("k1_last", got_q[15], 16'h0f00);
    drop_enable();

    // Invalid sizes: straight to FIN, no strobes
    @(negedge clk);
    imgSize = 16'd3;
    filterSize = 16'd4;
    enable = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk);
      #1;
      chk("inv_done", 16'(done), 16'd0);
    end
    chk("inv_state", 16'(dut.state_reg), 16'(FIN));
    drop_enable();

    // Abort at edge 5, then restart cleanly
    load_basic();
    @(negedge clk);
    imgSize = 16'd6;
    filterSize = 16'd3;
    enable = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_pre_done", 16'(done), 16'd0);
    drop_enable();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("abort_quiet", 16'(done), 16'd0);
    end
    run_conv(6, 3);
    chk("restart_p0", got_q[0], 16'h2400);
    drop_enable();

    // Asynchronous reset right after the first strobe
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #2;
    chk("pre_rst_done", 16'(done), 16'd1);
    chk("pre_rst_pix", convolved, 16'h2400);
    reset = 1'b0;
    #1;
    chk("async_convolved", convolved, 16'h0000);
    chk("async_done", 16'(done), 16'd0);
    chk("async_state", 16'(dut.state_reg), 16'(IDLE));
    @(negedge clk);
    enable = 1'b0;
    reset = 1'b1;

    // Randomized sizes and data
    for (int run = 0; run < 4; run++) begin
      int k, n;
      k = int'($urandom_range(1, 5));
      n = int'($urandom_range(k, 9));
      for (int x = 0; x < 1024; x++)
        image[x] = (run % 2 == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 4095)) - 2048);
      for (int x = 0; x < 25; x++)
        filter[x] = (run % 2 == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 4095)) - 2048);
      run_conv(n, k);
      chk("rand_count", 16'(got_q.size()), 16'((n - k + 1) * (n - k + 1)));
      drop_enable();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
